// File: rtl/ml_qspi_target_model.sv
// Oversampled QSPI target emulating the MARLANN host link over a byte memory.
// Define ML_QSPI_MODEL_WRAP_EN to wrap addresses modulo MEM_BYTES instead of flagging out-of-range access.
module ml_qspi_target_model #(
  parameter int    MEM_BYTES    = 1024,
  parameter int    DUMMY_CYCLES = 8,
  parameter int    IRQ_LATENCY  = 16,
  parameter string INIT_FILE    = ""
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ml_clk,
  input  logic       ml_csb,
  input  logic [3:0] ml_io_in,
  output logic [3:0] ml_io_out,
  output logic [3:0] ml_io_oe,
  output logic       ml_irq,
  output logic       ml_err
);
  localparam int ADDR_BITS = $clog2(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_STATUS, S_IGNORE
  } state_t;

  logic [5:0]           sync1_q, sync2_q;
  logic                 sclk_prev_q, csb_prev_q;
  state_t               state_q;
  logic [7:0]           cmd_q;
  logic [22:0]          sr_q;
  logic [7:0]           cnt_q;
  logic [2:0]           bit_q;
  logic                 half_q;
  logic [3:0]           nib_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 oor_q;
  logic                 arm_q, clr_q;
  logic [15:0]          irq_cnt_q;
  logic                 irq_run_q, irq_q, err_q;
  logic [3:0]           out_q, oe_q;
  logic [7:0]           mem_q [MEM_BYTES];

  logic                 sclk_s, csb_s;
  logic [3:0]           io_s;
  logic                 sclk_rise, sclk_fall, csb_rise, csb_fall;
  logic [7:0]           cmd_byte, rd_byte, status_byte;
  logic [23:0]          addr_full;
  logic                 in_range, load_oor, oor_nxt, wr_en;
  logic [ADDR_BITS-1:0] addr_nxt;

  assign {sclk_s, csb_s, io_s} = sync2_q;
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign csb_rise    = csb_s & ~csb_prev_q;
  assign csb_fall    = ~csb_s & csb_prev_q;
  assign cmd_byte    = {sr_q[6:0], io_s[0]};
  assign addr_full   = {sr_q, io_s[0]};
  assign in_range    = !oor_q && (32'(addr_q) < 32'(MEM_BYTES));
  assign rd_byte     = in_range ? mem_q[addr_q] : 8'h00;
  assign status_byte = {6'b000000, err_q, irq_q};
  assign wr_en       = (state_q == S_WDATA) && sclk_rise && half_q && in_range && !csb_rise;

  assign ml_io_out = out_q;
  assign ml_io_oe  = oe_q;
  assign ml_irq    = irq_q;
  assign ml_err    = err_q;

  // Address advance and out-of-range tracking for the selected wrap policy
  always_comb begin
`ifdef ML_QSPI_MODEL_WRAP_EN
    if (32'(addr_q) >= 32'(MEM_BYTES - 1)) begin
      addr_nxt = '0;
    end else begin
      addr_nxt = addr_q + ADDR_BITS'(1);
    end
    oor_nxt  = 1'b0;
    load_oor = 1'b0;
`else
    addr_nxt = addr_q + ADDR_BITS'(1);
    oor_nxt  = oor_q || (32'(addr_q) >= 32'(MEM_BYTES - 1));
    load_oor = |addr_full[23:ADDR_BITS];
`endif
  end

  // Memory contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr_q] <= {nib_q, io_s};
  end

  // Link synchronisers, protocol FSM, IRQ timer and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 6'd0; sync2_q <= 6'd0;
      sclk_prev_q <= 1'b0; csb_prev_q <= 1'b0;
      state_q <= S_IDLE; cmd_q <= 8'h00; sr_q <= 23'd0; cnt_q <= 8'd0;
      bit_q <= 3'd7; half_q <= 1'b0; nib_q <= 4'h0;
      addr_q <= '0; oor_q <= 1'b0; arm_q <= 1'b0; clr_q <= 1'b0;
      irq_cnt_q <= 16'd0; irq_run_q <= 1'b0; irq_q <= 1'b0; err_q <= 1'b0;
      out_q <= 4'h0; oe_q <= 4'h0;
    end else begin
      sync1_q     <= {ml_clk, ml_csb, ml_io_in};
      sync2_q     <= sync1_q;
      sclk_prev_q <= sclk_s;
      csb_prev_q  <= csb_s;
      if (irq_run_q) begin
        irq_cnt_q <= irq_cnt_q - 16'd1;
        if (irq_cnt_q == 16'd1) begin
          irq_q     <= 1'b1;
          irq_run_q <= 1'b0;
        end
      end
      if (csb_rise) begin
        state_q <= S_IDLE;
        out_q   <= 4'h0;
        oe_q    <= 4'h0;
        arm_q   <= 1'b0;
        clr_q   <= 1'b0;
        if ((((state_q == S_CMD) || (state_q == S_ADDR)) && (cnt_q[2:0] != 3'd0)) ||
            ((state_q == S_WDATA) && half_q)) begin
          err_q <= 1'b1;
        end
        if (arm_q) begin
          irq_cnt_q <= 16'(IRQ_LATENCY - 1);
          if (IRQ_LATENCY == 1) irq_q <= 1'b1;
          else irq_run_q <= 1'b1;
        end
        // Clear is applied last so it beats a same-cycle expiry
        if (clr_q) begin
          irq_q     <= 1'b0;
          err_q     <= 1'b0;
          irq_run_q <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (csb_fall) begin
              state_q <= S_CMD;
              cnt_q   <= 8'd0;
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              sr_q  <= {sr_q[21:0], io_s[0]};
              cnt_q <= cnt_q + 8'd1;
              if (cnt_q == 8'd7) begin
                cnt_q <= 8'd0;
                cmd_q <= cmd_byte;
                case (cmd_byte)
                  8'h03, 8'h01, 8'h6B: state_q <= S_ADDR;
                  8'h05: begin state_q <= S_STATUS; bit_q <= 3'd7; end
                  8'h10: begin state_q <= S_IGNORE; arm_q <= 1'b1; end
                  8'h11: begin state_q <= S_IGNORE; clr_q <= 1'b1; end
                  default: begin state_q <= S_IGNORE; err_q <= 1'b1; end
                endcase
              end
            end
          end
          S_ADDR: begin
            if (sclk_rise) begin
              sr_q  <= {sr_q[21:0], io_s[0]};
              cnt_q <= cnt_q + 8'd1;
              if (cnt_q == 8'd23) begin
                cnt_q  <= 8'd0;
                addr_q <= addr_full[ADDR_BITS-1:0];
                oor_q  <= load_oor;
                bit_q  <= 3'd7;
                half_q <= (cmd_q == 8'h6B);
                case (cmd_q)
                  8'h03: state_q <= S_RDATA;
                  8'h6B: state_q <= (DUMMY_CYCLES == 0) ? S_RDATA : S_DUMMY;
                  8'h01: state_q <= S_WDATA;
                  default: state_q <= S_IGNORE;
                endcase
              end
            end
          end
          S_DUMMY: begin
            if (sclk_rise) begin
              cnt_q <= cnt_q + 8'd1;
              if (cnt_q == 8'(DUMMY_CYCLES - 1)) state_q <= S_RDATA;
            end
          end
          S_RDATA: begin
            if (sclk_fall) begin
              if (cmd_q == 8'h6B) begin
                oe_q <= 4'hF;
                if (half_q) begin
                  out_q  <= rd_byte[7:4];
                  half_q <= 1'b0;
                  if (!in_range) err_q <= 1'b1;
                end else begin
                  out_q  <= rd_byte[3:0];
                  half_q <= 1'b1;
                  addr_q <= addr_nxt;
                  oor_q  <= oor_nxt;
                end
              end else begin
                oe_q  <= 4'b0010;
                out_q <= {2'b00, rd_byte[bit_q], 1'b0};
                bit_q <= bit_q - 3'd1;
                if ((bit_q == 3'd7) && !in_range) err_q <= 1'b1;
                if (bit_q == 3'd0) begin
                  addr_q <= addr_nxt;
                  oor_q  <= oor_nxt;
                end
              end
            end
          end
          S_WDATA: begin
            if (sclk_rise) begin
              if (!half_q) begin
                nib_q  <= io_s;
                half_q <= 1'b1;
              end else begin
                half_q <= 1'b0;
                addr_q <= addr_nxt;
                oor_q  <= oor_nxt;
                if (!in_range) err_q <= 1'b1;
              end
            end
          end
          S_STATUS: begin
            if (sclk_fall) begin
              oe_q  <= 4'b0010;
              out_q <= {2'b00, status_byte[bit_q], 1'b0};
              bit_q <= bit_q - 3'd1;
            end
          end
          S_IGNORE: begin
            oe_q <= 4'h0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule
